ecdh_des_sequencer: RTL

Parametrised top-level sequencer for the ECDH + 3DES core. It runs two ECC scalar-multiply phases: phase 1 publishes the public point, and phase 2 derives and latches the 3DES session key. It then paces a 3DES session through key setup, pipeline fill, streaming and drain. New behaviour beyond the first-generation controller:
- every width and latency is a parameter;
- the session key is registered and guarded by a valid flag;
- ECC runs have a watchdog timeout;
- each DES session carries an encrypt/decrypt mode.

---
 rtl/ecdh_des_pkg.sv | 45 ++++
 rtl/ecdh_des_sequencer_if.sv | 40 ++++
 rtl/seq_counter.sv | 28 ++
 rtl/ecdh_des_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ecdh_des_pkg.sv
// Shared definitions for the ECDH + 3DES sequencer.
// Contents: sequencer state enum, default width/latency constants and the
// session-key packing function used when phase 2 completes.
package ecdh_des_pkg;

  localparam int PT_W_DEF    = 163;
  localparam int KEY_W_DEF   = 192;
  localparam int DES_LAT_DEF = 48;

  // Upper bounds that size the packing function (largest standard binary
  // field degree); the sequencer checks its parameters against them.
  localparam int PT_W_MAX  = 571;
  localparam int KEY_W_MAX = 2 * PT_W_MAX + 1;

  typedef enum logic [3:0] {
    IDLE,
    ECC1,
    ECC2,
    ECC1_DONE,
    ECC2_DONE,
    ECC_ERR,
    KEY_WAIT,
    INIT_WAIT,
    DATA_WAIT,
    DES_DONE
  } seq_state_e;

  // Session key = {y[key_w-pt_w-1:0], x[pt_w-1:0]}, built bit by bit so one
  // function serves every legal (pt_w, key_w) pair. Bits above key_w are 0.
  function automatic logic [KEY_W_MAX-1:0] pack_key(input logic [PT_W_MAX:0] x,
                                                     input logic [PT_W_MAX:0] y,
                                                     input int pt_w,
                                                     input int key_w);
    logic [KEY_W_MAX-1:0] k;
    k = '0;
    for (int i = 0; i < KEY_W_MAX; i++) begin
      if (i < pt_w)
        k[i] = x[i];
      else if (i < key_w)
        k[i] = y[i - pt_w];
    end
    return k;
  endfunction

endpackage

// File: rtl/ecdh_des_sequencer_if.sv
// Request/response bundle between the sequencer and its environment.
// slave : sequencer side (takes requests and ECC results, drives control,
//         key material and status pulses).
// master: controller/engine side, the mirror image.
interface ecdh_des_sequencer_if
  import ecdh_des_pkg::*;
#(
  parameter int PT_W  = PT_W_DEF,
  parameter int KEY_W = KEY_W_DEF
);
  logic             ecc_start1;
  logic             ecc_start2;
  logic             des_start;
  logic             des_mode;
  logic             estart;
  logic [PT_W:0]    pox;
  logic [PT_W:0]    poy;
  logic             edone;
  logic [KEY_W-1:0] keys;
  logic             key_valid;
  logic             des_encrypt;
  logic [PT_W:0]    pux;
  logic [PT_W:0]    puy;
  logic             ecc1_done;
  logic             ecc2_done;
  logic             ecc_err;
  logic             des_done;

  modport slave (
    input  ecc_start1, ecc_start2, des_start, des_mode, pox, poy, edone,
    output estart, keys, key_valid, des_encrypt, pux, puy,
           ecc1_done, ecc2_done, ecc_err, des_done
  );

  modport master (
    output ecc_start1, ecc_start2, des_start, des_mode, pox, poy, edone,
    input  estart, keys, key_valid, des_encrypt, pux, puy,
           ecc1_done, ecc2_done, ecc_err, des_done
  );
endinterface

// File: rtl/seq_counter.sv
// Shared state counter for the sequencer.
// Ports: clk, n_rst (async, active-low), load (sync reload to 1, wins over
// en), en (increment), limit (compare value), count, tc (count == limit).
module seq_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_reg <= W'(1);
    else if (load)
      count_reg <= W'(1);
    else if (en)
      count_reg <= count_reg + W'(1);
  end

  assign count = count_reg;
  assign tc    = (count_reg == limit);
endmodule

// File: rtl/ecdh_des_sequencer.sv
// Top-level sequencer for the ECDH + 3DES core.
// Runs ECC phase 1 (public point -> pux/puy) and phase 2 (shared secret ->
// keys/key_valid), with an optional ECC watchdog, then paces a 3DES session
// through key setup, pipeline fill, streaming and drain.
// Ports: clk, n_rst (async, active-low), bus (slave modport: requests,
// ECC results in; estart, key material, status pulses, des_done out).
// Every output is a register loaded from the current state, so each
// response appears one cycle after the state that causes it.
module ecdh_des_sequencer
  import ecdh_des_pkg::*;
#(
  parameter int PT_W        = PT_W_DEF,
  parameter int KEY_W       = KEY_W_DEF,
  parameter int KEY_SETUP   = 2,
  parameter int DES_LAT     = DES_LAT_DEF,
  parameter int ECC_TIMEOUT = 0
) (
  input logic                  clk,
  input logic                  n_rst,
  ecdh_des_sequencer_if.slave  bus
);
  localparam int CNT_MAX0 = (DES_LAT > ECC_TIMEOUT) ? DES_LAT : ECC_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > KEY_SETUP) ? CNT_MAX0 : KEY_SETUP;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int PW       = PT_W_MAX + 1;
  localparam bit ECC_WD   = (ECC_TIMEOUT > 0);

  localparam logic [CW-1:0] LIM_KEY = CW'(KEY_SETUP);
  localparam logic [CW-1:0] LIM_DES = CW'(DES_LAT);
  localparam logic [CW-1:0] LIM_ECC = CW'(ECC_TIMEOUT);

  if (PT_W < 1 || PT_W > PT_W_MAX) begin : g_chk_pt_w
    $error("ecdh_des_sequencer: PT_W out of range");
  end
  if (KEY_W <= PT_W || KEY_W > 2 * PT_W + 1) begin : g_chk_key_w
    $error("ecdh_des_sequencer: KEY_W must satisfy PT_W < KEY_W <= 2*PT_W+1");
  end
  if (KEY_SETUP < 1) begin : g_chk_key_setup
    $error("ecdh_des_sequencer: KEY_SETUP must be >= 1");
  end
  if (DES_LAT < 1) begin : g_chk_des_lat
    $error("ecdh_des_sequencer: DES_LAT must be >= 1");
  end
  if (ECC_TIMEOUT < 0) begin : g_chk_timeout
    $error("ecdh_des_sequencer: ECC_TIMEOUT must be >= 0");
  end

  seq_state_e       state_reg, state_next;
  logic [CW-1:0]    cnt_limit;
  logic [CW-1:0]    cnt_value;
  logic             cnt_load, cnt_en, cnt_tc;
  logic [KEY_W-1:0] key_packed;

  logic             estart_reg, key_valid_reg, des_encrypt_reg;
  logic             ecc1_done_reg, ecc2_done_reg, ecc_err_reg, des_done_reg;
  logic [PT_W:0]    pux_reg, puy_reg;
  logic [KEY_W-1:0] keys_reg;

  seq_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (cnt_limit),
    .count (cnt_value),
    .tc    (cnt_tc)
  );

  assign key_packed = KEY_W'(pack_key(PW'(bus.pox), PW'(bus.poy), PT_W, KEY_W));

  // Next-state decode. The counter reloads to 1 on every state change, so
  // inside a counted state cnt_value is the 1-based cycle index.
  always_comb begin
    state_next = state_reg;
    cnt_limit  = '0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.ecc_start1)
          state_next = ECC1;
        else if (bus.ecc_start2)
          state_next = ECC2;
        else if (bus.des_start && key_valid_reg)
          state_next = KEY_WAIT;
      end
      ECC1, ECC2: begin
        cnt_limit = LIM_ECC;
        // With the watchdog off the counter is frozen so it cannot wrap.
        cnt_en    = ECC_WD;
        // edone is checked first so it wins over a coincident timeout.
        if (bus.edone)
          state_next = (state_reg == ECC1) ? ECC1_DONE : ECC2_DONE;
        else if (ECC_WD && cnt_tc)
          state_next = ECC_ERR;
      end
      ECC1_DONE, ECC2_DONE, ECC_ERR: state_next = IDLE;
      KEY_WAIT: begin
        cnt_limit = LIM_KEY;
        cnt_en    = 1'b1;
        if (cnt_tc)
          state_next = INIT_WAIT;
      end
      INIT_WAIT: begin
        cnt_limit = LIM_DES;
        cnt_en    = 1'b1;
        if (cnt_tc)
          state_next = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (!bus.des_start)
          state_next = DES_DONE;
      end
      DES_DONE: begin
        cnt_limit = LIM_DES;
        cnt_en    = 1'b1;
        if (cnt_tc)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    cnt_load = (state_next != state_reg);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= IDLE;
      estart_reg      <= 1'b0;
      key_valid_reg   <= 1'b0;
      des_encrypt_reg <= 1'b0;
      ecc1_done_reg   <= 1'b0;
      ecc2_done_reg   <= 1'b0;
      ecc_err_reg     <= 1'b0;
      des_done_reg    <= 1'b0;
      pux_reg         <= '0;
      puy_reg         <= '0;
      keys_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      estart_reg    <= (state_reg == ECC1) || (state_reg == ECC2);
      ecc1_done_reg <= (state_reg == ECC1_DONE);
      ecc2_done_reg <= (state_reg == ECC2_DONE);
      ecc_err_reg   <= (state_reg == ECC_ERR);
      des_done_reg  <= (state_reg == DATA_WAIT) || (state_reg == DES_DONE);
      if (state_reg == ECC1_DONE) begin
        pux_reg <= bus.pox;
        puy_reg <= bus.poy;
      end
      if (state_reg == ECC2_DONE) begin
        keys_reg      <= key_packed;
        key_valid_reg <= 1'b1;
      end
      if (state_reg == IDLE && state_next == KEY_WAIT)
        des_encrypt_reg <= bus.des_mode;
    end
  end

  assign bus.estart      = estart_reg;
  assign bus.keys        = keys_reg;
  assign bus.key_valid   = key_valid_reg;
  assign bus.des_encrypt = des_encrypt_reg;
  assign bus.pux         = pux_reg;
  assign bus.puy         = puy_reg;
  assign bus.ecc1_done   = ecc1_done_reg;
  assign bus.ecc2_done   = ecc2_done_reg;
  assign bus.ecc_err     = ecc_err_reg;
  assign bus.des_done    = des_done_reg;
endmodule
